// File: rtl/flat_history_buffer.sv
// flat_history_buffer: multi-channel sample history with a flattened output view.
// Stage 0 holds the newest accepted vector; older vectors move one stage deeper on
// every accepted vector. Idle, frozen or flushed cycles do not age the history.
// The is_signed parameter only marks the words as two's complement for consumers.
// Bit storage, ordering and reset values are identical in both modes.
module flat_history_buffer #(
  parameter int numChannels = 16,
  parameter int bitwidth    = 8,
  parameter int depth       = 5,
  parameter bit is_signed   = 1'b0,
  localparam int FILL_W     = $clog2(depth + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [bitwidth-1:0] in [numChannels],
  input  logic                in_valid,
  input  logic                freeze,
  input  logic                clear,
  output logic [bitwidth-1:0] flat_out [numChannels*depth],
  output logic                out_valid,
  output logic                out_update,
  output logic [FILL_W-1:0]   fill_count,
  output logic                overrun
);

  localparam logic [FILL_W-1:0] DEPTH_FILL = FILL_W'(depth);

  logic [bitwidth-1:0] stage [depth][numChannels];
  logic                acc;
  logic                flush;

  // A vector is taken only when valid, not frozen and not being flushed
  assign acc   = in_valid & ~freeze & ~clear;
  assign flush = rst | clear;

  // History shift register: flush zeroes every stage, an accept shifts one stage
  always_ff @(posedge clk) begin
    if (flush) begin
      for (int d = 0; d < depth; d++) begin
        for (int c = 0; c < numChannels; c++) begin
          stage[d][c] <= '0;
        end
      end
    end else if (acc) begin
      for (int c = 0; c < numChannels; c++) begin
        stage[0][c] <= in[c];
      end
      for (int d = 1; d < depth; d++) begin
        for (int c = 0; c < numChannels; c++) begin
          stage[d][c] <= stage[d-1][c];
        end
      end
    end
  end

  // Fill tracking, full flag, update pulse and sticky overrun, all registered
  always_ff @(posedge clk) begin
    if (flush) begin
      fill_count <= '0;
      out_valid  <= 1'b0;
      out_update <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      out_update <= acc;
      if (acc) begin
        if (fill_count != DEPTH_FILL) begin
          fill_count <= fill_count + FILL_W'(1);
        end
        out_valid <= (fill_count >= DEPTH_FILL - FILL_W'(1));
      end
      if (in_valid & freeze) begin
        overrun <= 1'b1;
      end
    end
  end

  // Flatten the history so word d*numChannels+c is channel c of stage d
  always_comb begin
    for (int d = 0; d < depth; d++) begin
      for (int c = 0; c < numChannels; c++) begin
        flat_out[d*numChannels + c] = stage[d][c];
      end
    end
  end

  // Signed alias of the newest channel-0 word, handy when probing signed datapaths
  if (is_signed) begin : g_signed_view
    logic signed [bitwidth-1:0] newest_unused;
    assign newest_unused = stage[0][0];
  end

endmodule

// File: tb/tb_flat_history_buffer.sv
// tb_flat_history_buffer: scoreboard bench for flat_history_buffer.
// A depth-5 unsigned instance and a depth-1 signed instance share the same inputs.
module tb_flat_history_buffer;

  typedef logic [15:0][7:0] vec_t;

  typedef struct packed {
    logic [79:0][7:0] flat;
    logic [2:0]       fill;
    logic             ovalid;
    logic             upd;
    logic             orun;
    logic [15:0][7:0] flat1;
    logic             fill1;
    logic             ovalid1;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] in_vec [16];
  logic       in_valid;
  logic       freeze;
  logic       clear;

  logic [7:0] flat_out [80];
  logic       out_valid;
  logic       out_update;
  logic [2:0] fill_count;
  logic       overrun;

  logic [7:0] flat_out1 [16];
  logic       out_valid1;
  logic       out_update1;
  logic [0:0] fill_count1;
  logic       overrun1;

  int total = 0;
  int bad = 0;

  exp_t sb [$];
  vec_t hist [$];
  vec_t last1;
  bit   has1;
  bit   m_overrun;
  bit   m_update;

  flat_history_buffer #(
    .numChannels(16), .bitwidth(8), .depth(5), .is_signed(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .in(in_vec), .in_valid(in_valid), .freeze(freeze),
    .clear(clear), .flat_out(flat_out), .out_valid(out_valid),
    .out_update(out_update), .fill_count(fill_count), .overrun(overrun)
  );

  flat_history_buffer #(
    .numChannels(16), .bitwidth(8), .depth(1), .is_signed(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst), .in(in_vec), .in_valid(in_valid), .freeze(freeze),
    .clear(clear), .flat_out(flat_out1), .out_valid(out_valid1),
    .out_update(out_update1), .fill_count(fill_count1), .overrun(overrun1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(string name, logic [639:0] act, logic [639:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(int k);
    vec_t v;
    for (int c = 0; c < 16; c++) v[c] = 8'(16 * k + c);
    return v;
  endfunction

  // Drive one cycle of inputs, then advance the model and queue the expected response
  task automatic applyStimulus(input bit v, input bit f, input bit cl, input bit r,
                               input vec_t vec);
    exp_t e;
    bit   acc;
    in_valid = v;
    freeze   = f;
    clear    = cl;
    rst      = r;
    for (int c = 0; c < 16; c++) in_vec[c] = vec[c];
    @(posedge clk);
    acc = v & ~f & ~cl & ~r;
    if (r | cl) begin
      hist.delete();
      has1      = 1'b0;
      last1     = '0;
      m_overrun = 1'b0;
      m_update  = 1'b0;
    end else begin
      m_update = acc;
      if (acc) begin
        hist.push_front(vec);
        if (hist.size() > 5) void'(hist.pop_back());
        last1 = vec;
        has1  = 1'b1;
      end
      if (v & f) m_overrun = 1'b1;
    end
    e.flat = '0;
    for (int d = 0; d < hist.size(); d++) begin
      for (int c = 0; c < 16; c++) e.flat[d*16 + c] = hist[d][c];
    end
    e.fill    = 3'(hist.size());
    e.ovalid  = (hist.size() == 5);
    e.upd     = m_update;
    e.orun    = m_overrun;
    e.flat1   = last1;
    e.fill1   = has1;
    e.ovalid1 = has1;
    sb.push_back(e);
    #1;
  endtask

  // Compare both instances against one popped scoreboard entry
  task automatic checkOutput(input exp_t e);
    logic [79:0][7:0] af;
    logic [15:0][7:0] af1;
    for (int i = 0; i < 80; i++) af[i] = flat_out[i];
    for (int i = 0; i < 16; i++) af1[i] = flat_out1[i];
    check("flat_out", 640'(af), 640'(e.flat));
    check("fill_count", 640'(fill_count), 640'(e.fill));
    check("out_valid", 640'(out_valid), 640'(e.ovalid));
    check("out_update", 640'(out_update), 640'(e.upd));
    check("overrun", 640'(overrun), 640'(e.orun));
    check("d1_flat_out", 640'(af1), 640'(e.flat1));
    check("d1_fill_count", 640'(fill_count1), 640'(e.fill1));
    check("d1_out_valid", 640'(out_valid1), 640'(e.ovalid1));
    check("d1_out_update", 640'(out_update1), 640'(e.upd));
    check("d1_overrun", 640'(overrun1), 640'(e.orun));
  endtask

  // Monitor: pops and compares one expected response per cycle, away from the edge
  always @(negedge clk) begin
    if (sb.size() > 0) checkOutput(sb.pop_front());
  end

  // Hand-computed image of v1..v5 in order: word d*16+c = 16*(5-d)+c
  function automatic logic [639:0] filled_image();
    logic [79:0][7:0] img;
    for (int d = 0; d < 5; d++) begin
      for (int c = 0; c < 16; c++) img[d*16 + c] = 8'(16 * (5 - d) + c);
    end
    return 640'(img);
  endfunction

  function automatic logic [639:0] actual_image();
    logic [79:0][7:0] img;
    for (int i = 0; i < 80; i++) img[i] = flat_out[i];
    return 640'(img);
  endfunction

  initial begin
    vec_t sv;
    int   budget;
    in_valid = 1'b0;
    freeze   = 1'b0;
    clear    = 1'b0;
    rst      = 1'b0;
    for (int c = 0; c < 16; c++) in_vec[c] = '0;

    $display("[TB] reset");
    applyStimulus(0, 0, 0, 1, '0);
    applyStimulus(0, 0, 0, 0, '0);

    $display("[TB] fill and order");
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1, 0, 0, 0, mk(k));
      check("fill_seq", 640'(fill_count), 640'(k));
    end
    check("fill_image", actual_image(), filled_image());
    check("full_valid", 640'(out_valid), 640'(1));

    $display("[TB] gapped input");
    applyStimulus(0, 0, 1, 0, '0);
    applyStimulus(1, 0, 0, 0, mk(1));
    applyStimulus(1, 0, 0, 0, mk(2));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, mk(9));
      check("gap_fill", 640'(fill_count), 640'(2));
      check("gap_update", 640'(out_update), 640'(0));
    end
    for (int k = 3; k <= 5; k++) applyStimulus(1, 0, 0, 0, mk(k));
    check("gap_image", actual_image(), filled_image());

    $display("[TB] freeze and overrun");
    applyStimulus(1, 1, 0, 0, mk(7));
    applyStimulus(1, 1, 0, 0, mk(8));
    check("freeze_image", actual_image(), filled_image());
    applyStimulus(0, 0, 0, 0, '0);
    check("overrun_sticky", 640'(overrun), 640'(1));
    applyStimulus(1, 0, 0, 0, mk(6));
    check("v6_word0", 640'(flat_out[0]), 640'(96));
    check("v6_word64", 640'(flat_out[64]), 640'(32));

    $display("[TB] clear priority");
    applyStimulus(1, 0, 1, 0, mk(10));
    check("clear_fill", 640'(fill_count), 640'(0));
    check("clear_overrun", 640'(overrun), 640'(0));
    check("clear_update", 640'(out_update), 640'(0));
    applyStimulus(1, 0, 0, 0, mk(1));
    check("post_clear_fill", 640'(fill_count), 640'(1));

    $display("[TB] saturation and reset mid-stream");
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1, 0, 0, (k == 12), mk(k));
      if (k == 12) check("rst_fill", 640'(fill_count), 640'(0));
      if (k == 13) check("refill", 640'(fill_count), 640'(1));
    end

    $display("[TB] signed depth-1");
    sv = '0;
    sv[0] = 8'h80;
    sv[1] = 8'hFF;
    applyStimulus(1, 0, 0, 0, sv);
    check("signed_w0", 640'($signed(flat_out1[0]) == -8'sd128), 640'(1));
    check("signed_w1", 640'($signed(flat_out1[1]) == -8'sd1), 640'(1));
    applyStimulus(1, 0, 0, 0, mk(3));
    check("d1_overwrite", 640'(flat_out1[0]), 640'(48));
    applyStimulus(0, 0, 0, 0, '0);

    budget = 10;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    total++;
    if (sb.size() > 0) begin
      bad++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
